// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encoding
// and the bit-counter width helper.
package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // A one-bit counter is still needed when W=1 so RUN has a defined index.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/fa_bit_reg.sv
// Single full-adder bit cell whose sum and carry are registered, so the carry
// chain advances one bit per clock.
module fa_bit_reg (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic sum_d, sum_q;
  logic cout_d, cout_q;

  always_comb begin
    sum_d  = a ^ b ^ cin;
    cout_d = (a & b) | (a & cin) | (b & cin);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= 1'b0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: feeds operands LSB first through one registered
// full-adder cell and collects the sum bits into a result shift register.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         cin_in,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout_out
);

  localparam int            CW       = cnt_width(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  state_e        state_d, state_q;
  logic [W-1:0]  a_sh_d, a_sh_q;
  logic [W-1:0]  b_sh_d, b_sh_q;
  logic [W-1:0]  result_d, result_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic          cin_d, cin_q;
  logic          cout_d, cout_q;
  logic          ready_d, ready_q;
  logic          busy_d, busy_q;
  logic          done_d, done_q;

  logic          fa_sum, fa_cout, fa_cin;
  logic [W:0]    res_shift;

  // Bit 0 takes the latched carry-in; later bits chain the cell's own carry.
  assign fa_cin    = (cnt_q == '0) ? cin_q : fa_cout;
  assign res_shift = {fa_sum, result_q};

  fa_bit_reg u_fa (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (fa_cin),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    cin_d    = cin_q;
    cout_d   = cout_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sh_d  = op_a;
          b_sh_d  = op_b;
          cin_d   = cin_in;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        cnt_d  = cnt_q + 1'b1;
        // The cell's sum register lags by one bit, so nothing is valid at k=0.
        if (cnt_q != '0) result_d = res_shift[W:1];
        if (cnt_q == CNT_LAST) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        result_d = res_shift[W:1];
        cout_d   = fa_cout;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      cin_q    <= 1'b0;
      cout_q   <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      cin_q    <= cin_d;
      cout_q   <= cout_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign ready    = ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign cout_out = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at W=8 and W=1 against an
// arithmetic/timing reference model.
module tb_serial_add_ctrl;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      start, cin, ready, busy, done, cout;
  logic [1:0][7:0] op_a, op_b;
  logic [7:0]      res0;
  logic [0:0]      res1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .op_a(op_a[0]), .op_b(op_b[0]),
    .cin_in(cin[0]), .ready(ready[0]), .busy(busy[0]), .done(done[0]),
    .result(res0), .cout_out(cout[0])
  );

  serial_add_ctrl #(.W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .op_a(op_a[1][0:0]), .op_b(op_b[1][0:0]),
    .cin_in(cin[1]), .ready(ready[1]), .busy(busy[1]), .done(done[1]),
    .result(res1), .cout_out(cout[1])
  );

  function automatic int wid(input int i);
    return (i == 0) ? 8 : 1;
  endfunction

  function automatic logic [8:0] dut_val(input int i);
    return (i == 0) ? {cout[0], res0} : {7'd0, cout[1], res1};
  endfunction

  function automatic logic [8:0] ref_sum(input int i, input logic [7:0] a, input logic [7:0] b,
                                         input logic c);
    int m, s;
    m = (1 << wid(i)) - 1;
    s = (int'(a) & m) + (int'(b) & m) + int'(c);
    s = s & ((m << 1) | 1);
    return s[8:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: an accepted op keeps the unit busy for W+2 cycles, the
  // last of which is the done cycle; the sum is plain integer addition.
  int         left[2];
  logic [8:0] exp_v[2];
  bit         have[2];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        left[i]  = 0;
        exp_v[i] = '0;
        have[i]  = 1'b1;
      end else if (left[i] == 0) begin
        if (start[i]) begin
          left[i]  = wid(i) + 2;
          exp_v[i] = ref_sum(i, op_a[i], op_b[i], cin[i]);
          have[i]  = 1'b0;
        end
      end else begin
        left[i]--;
        if (left[i] == 0) have[i] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("ready%0d", i), 32'(ready[i]), 32'(left[i] == 0));
        chk($sformatf("busy%0d", i), 32'(busy[i]), 32'(left[i] != 0));
        chk($sformatf("done%0d", i), 32'(done[i]), 32'(left[i] == 1));
        if (left[i] == 1 || (left[i] == 0 && have[i]))
          chk($sformatf("sum%0d", i), 32'(dut_val(i)), 32'(exp_v[i]));
      end
    end
  end

  task automatic run_op(input int i, input logic [7:0] a, input logic [7:0] b, input logic c,
                        input bit hold, input int poke, output int cyc, output logic [8:0] got);
    int g;
    g = 0;
    while (ready[i] !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) begin
      checks++;
      failures++;
      $display("FAIL ready_wait dut%0d: got not-ready expected ready", i);
    end
    start[i] = 1'b1;
    op_a[i]  = a;
    op_b[i]  = b;
    cin[i]   = c;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!hold) begin
        start[i] = (cyc == poke);
        op_a[i]  = (cyc == poke) ? 8'h11 : 8'($urandom);
        op_b[i]  = 8'($urandom);
        cin[i]   = 1'($urandom);
      end
    end while (done[i] !== 1'b1 && cyc < 40);
    if (done[i] !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL done_wait dut%0d: got no done expected done", i);
    end
    got = dut_val(i);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         cyc, n;
    logic [8:0] got;
    logic [7:0] ra, rb;
    logic       rc;

    start = '0;
    cin   = '0;
    op_a  = '0;
    op_b  = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_ready%0d", i), 32'(ready[i]), 32'd1);
      chk($sformatf("rst_busy%0d", i), 32'(busy[i]), 32'd0);
      chk($sformatf("rst_done%0d", i), 32'(done[i]), 32'd0);
      chk($sformatf("rst_val%0d", i), 32'(dut_val(i)), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    run_op(0, 8'h5A, 8'h3C, 1'b0, 1'b0, -1, cyc, got);
    chk("lat_5a3c", 32'(cyc), 32'd10);
    chk("sum_5a3c", 32'(got), 32'h096);
    @(negedge clk);
    chk("busy_after_done", 32'(busy[0]), 32'd0);
    chk("ready_after_done", 32'(ready[0]), 32'd1);

    run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, -1, cyc, got);
    chk("sum_ff01", 32'(got), 32'h100);
    run_op(0, 8'hFF, 8'hFF, 1'b1, 1'b0, -1, cyc, got);
    chk("sum_ffff1", 32'(got), 32'h1FF);
    run_op(0, 8'h00, 8'h00, 1'b1, 1'b0, -1, cyc, got);
    chk("sum_00001", 32'(got), 32'h001);

    run_op(0, 8'h22, 8'h33, 1'b0, 1'b0, 3, cyc, got);
    chk("busy_start_ignored", 32'(got), 32'h055);

    // start held high through DONE: the next op starts from the following IDLE cycle
    run_op(0, 8'h5A, 8'h3C, 1'b0, 1'b1, -1, cyc, got);
    chk("hold_first", 32'(got), 32'h096);
    op_a[0] = 8'h20;
    op_b[0] = 8'h22;
    cin[0]  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) chk("hold_ready_gap", 32'(ready[0]), 32'd1);
      if (n == 2) begin
        chk("hold_reaccepted", 32'(busy[0]), 32'd1);
        start[0] = 1'b0;
      end
    end while (done[0] !== 1'b1 && n < 40);
    chk("hold_period", 32'(n), 32'd11);
    chk("hold_second", 32'(dut_val(0)), 32'h043);

    run_op(1, 8'h01, 8'h01, 1'b1, 1'b0, -1, cyc, got);
    chk("w1_lat", 32'(cyc), 32'd3);
    chk("w1_sum111", 32'(got), 32'h003);
    run_op(1, 8'h01, 8'h00, 1'b0, 1'b0, -1, cyc, got);
    chk("w1_sum100", 32'(got), 32'h001);

    // asynchronous reset in the middle of RUN
    @(negedge clk);
    start[0] = 1'b1;
    op_a[0]  = 8'hC3;
    op_b[0]  = 8'h5E;
    cin[0]   = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 32'(busy[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(ready[0]), 32'd1);
    chk("mid_rst_busy", 32'(busy[0]), 32'd0);
    chk("mid_rst_done", 32'(done[0]), 32'd0);
    chk("mid_rst_val", 32'(dut_val(0)), 32'd0);
    repeat (2) @(negedge clk);
    chk("mid_rst_no_done", 32'(done[0]), 32'd0);
    rst_n = 1'b1;
    run_op(0, 8'h01, 8'h02, 1'b0, 1'b0, -1, cyc, got);
    chk("post_rst_sum", 32'(got), 32'h003);

    for (int k = 0; k < 400; k++) begin
      int i;
      i  = k & 1;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      run_op(i, ra, rb, rc, 1'b0, -1, cyc, got);
      chk($sformatf("rand_sum%0d", i), 32'(got), 32'(ref_sum(i, ra, rb, rc)));
      chk($sformatf("rand_lat%0d", i), 32'(cyc), 32'(wid(i) + 2));
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller that adds two W-bit operands by sequencing one registered 1-bit full-adder cell, one bit per clock, LSB first.
- Captures operands on a start handshake and runs the carry chain through the cell's registered carry output.
- Shifts the registered sum bits into a result register, then pulses done.
- Sits between a requester, such as a bench or a higher-level ALU sequencer, and the single shared adder bit-cell.

Parameters:
W, 8, operand/result width in bits (W >= 1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
start  input  1  request; accepted only when ready=1
op_a  input  W  operand A, sampled at the accepting edge
op_b  input  W  operand B, sampled at the accepting edge
cin_in  input  1  carry-in for bit 0, sampled at the accepting edge
ready  output  1  high only in IDLE
busy  output  1  high in RUN, FLUSH and DONE
done  output  1  one-cycle pulse; result and cout_out valid
result  output  W  sum; held until the next accepted start
cout_out  output  1  carry out of bit W-1; held with result

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset state:
  - state=IDLE, ready=1, busy=0, done=0.
  - result=0, cout_out=0, bit counter=0, operand shift registers=0, carry-in latch=0.
  - The adder cell's sum and cout registers also clear to 0.
- FSM states and transitions:
  - IDLE: start=1 at an edge loads op_a, op_b and cin_in into internal registers, clears the counter, and moves to RUN.
  - RUN (W cycles):
    - In cycle k (k=0..W-1), the cell is presented a_sh[0], b_sh[0] and carry.
    - carry = cin latch when k==0, otherwise the cell's registered cout.
    - At each edge the cell registers sum/cout, the operand shift registers shift right, and the counter increments.
    - For k>=1, the cell's registered sum (bit k-1) shifts into the result shift register from the MSB side.
    - Leaves to FLUSH after k==W-1.
  - FLUSH (1 cycle): shifts in the last sum bit and captures the cell's cout into cout_out. Moves to DONE.
  - DONE (1 cycle): done=1 and result is final. Moves to IDLE unconditionally.
- Latency: start accepted at the edge ending cycle 0 gives done=1 in cycle W+2. Throughput is one operation per W+3 cycles.
- start rules:
  - Ignored while busy, including in DONE; no queuing.
  - start held continuously is re-accepted in the first IDLE cycle after DONE.
- Visibility: result is updated only by the shifting in RUN/FLUSH. Intermediate values are visible but are defined valid only while done=1 or ready=1 after a completed operation.
- Arithmetic: {cout_out, result} = op_a + op_b + cin_in, modulo 2^(W+1).
- Counter: width max(1, $clog2(W)). When W=1, RUN lasts exactly one cycle.
- Reset mid-operation: immediate return to reset values. No done pulse, and no partial result is retained.
- Inputs: op_a, op_b and cin_in are don't-care except at the accepting edge.

Decomposition:
- Shared package serial_add_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_FLUSH=2'd2, ST_DONE=2'd3.
  - A counter-width helper function.
- One sub-module, fa_bit_reg: 1-bit full adder with registered sum and cout (clk, rst_n, a, b, cin -> sum, cout), instantiated once.
- The FSM, shift registers and counter stay in serial_add_ctrl.

Test Plan:
- W=8, start with a=0x5A, b=0x3C, cin=0 -> done pulse in cycle 10 after the start cycle, result=0x96, cout_out=0, busy low one cycle later.
- a=0xFF, b=0x01, cin=0 -> result=0x00, cout_out=1 (full carry ripple through all bits).
- a=0xFF, b=0xFF, cin=1 -> result=0xFF, cout_out=1. Then a=0x00, b=0x00, cin=1 -> result=0x01, cout_out=0 (the carry latch must not leak across operations).
- Timing of start while busy:
  - Pulse start with a=0x11 in cycle 3 of an active run -> ignored; the original operands' sum is reported.
  - Hold start high through DONE -> the second operation begins only after ready=1.
- Assert rst_n=0 asynchronously mid-RUN (between edges) -> outputs drop to reset values immediately, no done pulse. After release, a new start with 0x01+0x02 -> result=0x03.
- Random compare: 200 random (a, b, cin) at W=8 and W=1 -> {cout_out, result} equals a+b+cin, and done is exactly one cycle wide each time.
